// File: rtl/l1_frame_arbiter.sv
// l1_frame_arbiter: sequences the L1 frame RAM.
// Port A is filled by the pixel stream through a linear write counter.
// Port B is shared by two read clients through a round-robin arbiter.
// Reads are granted only while a complete frame is resident.
// Optional macro L1ARB_READ_BEHIND_EN also lets reads proceed during a fill.
// With that macro, a read is eligible if it targets a pixel already written.
//
// Read handshake: rdN_req is held until granted. rdN_gnt is combinational,
// in the same cycle as the request. rdN_valid rises exactly one cycle after
// the grant, and rd_data then carries the RAM's registered port-B output.
module l1_frame_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic              frame_ready,
    input  logic              frame_release,
    output logic              overflow,
    output logic              resync,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd0_gnt,
    output logic              rd1_gnt,
    output logic              rd0_valid,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] ram_address_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_wren_a,
    output logic [ADDR_W-1:0] ram_address_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_wren_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic              rr_ptr, rr_ptr_nxt;   // 0: rd0 wins a tie, 1: rd1 wins
    logic              set_overflow, set_resync;
    logic              elig0, elig1;
    logic              behind0, behind1;

    // A full frame is resident exactly while the FSM sits in DONE
    assign frame_ready = (state == ST_DONE);
    assign ram_data_a  = pix_data;
    assign ram_data_b  = '0;
    assign ram_wren_b  = 1'b0;
    assign rd_data     = ram_q_b;

    // Fill sequencing: write strobe, write address and next state
    always_comb begin
        state_nxt     = state;
        wr_addr_nxt   = wr_addr;
        ram_wren_a    = 1'b0;
        ram_address_a = wr_addr;
        set_overflow  = 1'b0;
        set_resync    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pix_valid && pix_sof) begin
                    ram_wren_a    = 1'b1;
                    ram_address_a = '0;
                    wr_addr_nxt   = ADDR_W'(1);
                    state_nxt     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (pix_valid) begin
                    ram_wren_a = 1'b1;
                    if (pix_sof) begin
                        // Camera restarted the frame: begin again from pixel 0
                        ram_address_a = '0;
                        wr_addr_nxt   = ADDR_W'(1);
                        set_resync    = 1'b1;
                    end else if (wr_addr == LAST_ADDR) begin
                        wr_addr_nxt = '0;
                        state_nxt   = ST_DONE;
                    end else begin
                        wr_addr_nxt = wr_addr + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (pix_valid)     set_overflow = 1'b1;
                if (frame_release) state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef L1ARB_READ_BEHIND_EN
    // Streaming reads: the address must already be written this frame, and it must not collide with this cycle's write
    assign behind0 = (state == ST_FILL) && (rd0_addr < wr_addr) &&
                     !(ram_wren_a && (rd0_addr == ram_address_a));
    assign behind1 = (state == ST_FILL) && (rd1_addr < wr_addr) &&
                     !(ram_wren_a && (rd1_addr == ram_address_a));
`else
    assign behind0 = 1'b0;
    assign behind1 = 1'b0;
`endif

    assign elig0 = rd0_req && ((state == ST_DONE) || behind0);
    assign elig1 = rd1_req && ((state == ST_DONE) || behind1);

    // Round-robin grant; the pointer always moves away from the port just served
    always_comb begin
        rd0_gnt       = elig0 && (!elig1 || !rr_ptr);
        rd1_gnt       = elig1 && (!elig0 || rr_ptr);
        ram_address_b = rd1_gnt ? rd1_addr : rd0_addr;
        rr_ptr_nxt    = rr_ptr;
        if (rd0_gnt)      rr_ptr_nxt = 1'b1;
        else if (rd1_gnt) rr_ptr_nxt = 1'b0;
    end

    // State, counters, sticky flags and read-valid pipeline
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_addr   <= '0;
            rr_ptr    <= 1'b0;
            overflow  <= 1'b0;
            resync    <= 1'b0;
            rd0_valid <= 1'b0;
            rd1_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_addr   <= wr_addr_nxt;
            rr_ptr    <= rr_ptr_nxt;
            overflow  <= overflow | set_overflow;
            resync    <= resync | set_resync;
            rd0_valid <= rd0_gnt;
            rd1_valid <= rd1_gnt;
        end
    end

endmodule

// File: tb/tb_l1_frame_arbiter.sv
// Bench for l1_frame_arbiter with a small frame, checked against a frame-level reference model.
// Covers a full frame fill, round-robin reads, overflow, and release.
// Also covers resync, read-behind streaming, mid-fill reset and a random soak.
module tb_l1_frame_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int FP = 1024;

`ifdef L1ARB_READ_BEHIND_EN
  localparam bit BEHIND = 1'b1;
`else
  localparam bit BEHIND = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, pix_valid, pix_sof, frame_release, rd0_req, rd1_req;
  logic [DW-1:0] pix_data;
  logic [AW-1:0] rd0_addr, rd1_addr;
  logic          frame_ready, overflow, resync, rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
  logic [DW-1:0] rd_data, ram_data_a, ram_data_b, ram_q_b;
  logic [AW-1:0] ram_address_a, ram_address_b;
  logic          ram_wren_a, ram_wren_b;

  l1_frame_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP)) dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .frame_ready(frame_ready), .frame_release(frame_release),
    .overflow(overflow), .resync(resync), .rd0_req(rd0_req), .rd0_addr(rd0_addr),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd0_gnt(rd0_gnt), .rd1_gnt(rd1_gnt),
    .rd0_valid(rd0_valid), .rd1_valid(rd1_valid), .rd_data(rd_data),
    .ram_address_a(ram_address_a), .ram_data_a(ram_data_a), .ram_wren_a(ram_wren_a),
    .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
    .ram_q_b(ram_q_b)
  );

  // Frame RAM fixture with a registered port-B output
  logic [DW-1:0] ram [0:FP-1];
  int wren_cnt = 0;
  always @(posedge clock) begin
    if (ram_wren_a) ram[ram_address_a[9:0]] <= ram_data_a;
    ram_q_b <= (ram_address_b < AW'(FP)) ? ram[ram_address_b[9:0]] : 8'h00;
    if (ram_wren_a) wren_cnt <= wren_cnt + 1;
  end

  // ---------------- reference model ----------------
  int total = 0;
  int bad   = 0;
  int m_phase;      // 0 waiting for sof, 1 capturing, 2 frame resident
  int m_next;       // next pixel index to be captured
  int m_rr;         // port that wins a tie
  bit m_ovf, m_res;
  logic [DW-1:0] m_mem [0:FP-1];
  logic [9:0] exp_q[$];   // {data_checked, port, data}

  typedef struct {
    logic r0, r1, g0, g1;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit readable(input int a, input bit wr, input int wa);
    if (m_phase == 2) return 1'b1;
    if (BEHIND && m_phase == 1 && a < m_next && !(wr && a == wa)) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- driver + per-cycle scoreboard ----------------
  task automatic step(input logic rst, input logic v, input logic sof, input logic [DW-1:0] d,
                      input logic rel, input logic r0, input logic r1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bit e_wr, e0, e1, g0, g1;
    int e_wa;
    logic [9:0] ent;
    @(negedge clock);
    reset = rst; pix_valid = v; pix_sof = sof; pix_data = d; frame_release = rel;
    rd0_req = r0; rd1_req = r1; rd0_addr = a0; rd1_addr = a1;
    #1;
    e_wr = 1'b0; e_wa = 0;
    if (m_phase == 0 && v && sof) begin e_wr = 1'b1; e_wa = 0; end
    else if (m_phase == 1 && v) begin e_wr = 1'b1; e_wa = sof ? 0 : m_next; end
    e0 = r0 && readable(int'(a0), e_wr, e_wa);
    e1 = r1 && readable(int'(a1), e_wr, e_wa);
    g0 = e0 && (!e1 || m_rr == 0);
    g1 = e1 && (!e0 || m_rr == 1);
    chk("frame_ready", frame_ready, m_phase == 2);
    chk("overflow", overflow, m_ovf);
    chk("resync", resync, m_res);
    chk("wren_a", ram_wren_a, e_wr);
    if (e_wr) begin
      chk("addr_a", ram_address_a, e_wa);
      chk("data_a", ram_data_a, d);
    end
    chk("gnt0", rd0_gnt, g0);
    chk("gnt1", rd1_gnt, g1);
    if (g0 || g1) chk("addr_b", ram_address_b, g1 ? a1 : a0);
    chk("port_b_idle", {ram_wren_b, ram_data_b}, 0);
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      chk("valid0", rd0_valid, !ent[8]);
      chk("valid1", rd1_valid, ent[8]);
      if (ent[9]) chk("rd_data", rd_data, ent[7:0]);
    end else begin
      chk("valid0", rd0_valid, 0);
      chk("valid1", rd1_valid, 0);
    end
    // advance model to the state after this edge
    if (g0) exp_q.push_back({a0 < AW'(FP), 1'b0, (a0 < AW'(FP)) ? m_mem[a0[9:0]] : 8'h00});
    if (g1) exp_q.push_back({a1 < AW'(FP), 1'b1, (a1 < AW'(FP)) ? m_mem[a1[9:0]] : 8'h00});
    if (e_wr) m_mem[e_wa] = d;
    if (rst) begin
      m_phase = 0; m_next = 0; m_rr = 0; m_ovf = 0; m_res = 0;
      exp_q.delete();
    end else begin
      if (g0) m_rr = 1; else if (g1) m_rr = 0;
      case (m_phase)
        0: if (v && sof) begin m_phase = 1; m_next = 1; end
        1: if (v) begin
             if (sof) begin m_next = 1; m_res = 1; end
             else if (m_next == FP - 1) begin m_next = 0; m_phase = 2; end
             else m_next = m_next + 1;
           end
        default: begin
          if (v) m_ovf = 1;
          if (rel) m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 0, 0, 0, '0, '0);
  endtask

  // one pixel whose value is its own address
  task automatic pix(input logic sof);
    step(0, 1, sof, sof ? 8'h00 : 8'(m_next), 0, 0, 0, '0, '0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0, a0i, a1i;
    logic r, v, s, rl, q0, q1;
    logic [AW-1:0] ad0, ad1;
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{1, 1, 1, 0};
    tbl[3] = '{0, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 1};
    tbl[5] = '{1, 1, 1, 0};
    tbl[6] = '{1, 0, 1, 0};
    tbl[7] = '{1, 1, 0, 1};
    tbl[8] = '{0, 0, 0, 0};
    tbl[9] = '{1, 1, 1, 0};
    for (int i = 0; i < FP; i++) begin ram[i] = '0; m_mem[i] = '0; end
    m_phase = 0; m_next = 0; m_rr = 0; m_ovf = 0; m_res = 0;
    reset = 1; pix_valid = 0; pix_sof = 0; pix_data = 0; frame_release = 0;
    rd0_req = 0; rd1_req = 0; rd0_addr = 0; rd1_addr = 0;

    step(1, 0, 0, 8'h00, 0, 0, 0, '0, '0);
    step(1, 0, 0, 8'h00, 0, 0, 0, '0, '0);
    idle();
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_resync", resync, 0);
    chk("rst_valid", {rd0_valid, rd1_valid}, 0);
    chk("rst_wren", ram_wren_a, 0);

    // stray pixels in IDLE are ignored, not overflow; and no grant without a frame
    step(0, 1, 0, 8'h55, 0, 1, 1, 5, 6);
    chk("idle_wren", ram_wren_a, 0);
    chk("idle_gnt", {rd0_gnt, rd1_gnt}, 0);
    idle();
    chk("idle_ovf", overflow, 0);

    // full frame fill
    c0 = wren_cnt;
    pix(1);
    repeat (FP - 1) pix(0);
    chk("last_write_ready", frame_ready, 0);
    idle();
    chk("fill_ready", frame_ready, 1);
    chk("fill_wren_count", wren_cnt - c0, FP);
    chk("fill_ovf", overflow, 0);

    // round-robin table in DONE
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 8'h00, 0, tbl[i].r0, tbl[i].r1, 5, 6);
      chk("tbl_gnt0", rd0_gnt, tbl[i].g0);
      chk("tbl_gnt1", rd1_gnt, tbl[i].g1);
    end
    idle();
    chk("tbl_last_data", rd_data, 8'h05);

    // out-of-range address is still granted
    step(0, 0, 0, 8'h00, 0, 1, 0, AW'(FP + 10), '0);
    chk("oor_gnt", rd0_gnt, 1);

    // pixels in DONE are dropped and set overflow
    repeat (3) begin
      step(0, 1, 0, 8'hEE, 0, 0, 0, '0, '0);
      chk("done_wren", ram_wren_a, 0);
    end
    idle();
    chk("done_ovf", overflow, 1);

    // read on the release cycle completes; nothing is granted afterwards
    step(0, 0, 0, 8'h00, 1, 1, 1, 5, 6);
    chk("rel_gnt", rd0_gnt | rd1_gnt, 1);
    step(0, 0, 0, 8'h00, 0, 1, 1, 5, 6);
    chk("rel_ready", frame_ready, 0);
    chk("rel_gnt_after", {rd0_gnt, rd1_gnt}, 0);
    chk("rel_valid", rd0_valid | rd1_valid, 1);
    step(0, 0, 0, 8'h00, 0, 1, 1, 5, 6);
    chk("rel_gnt_after2", {rd0_gnt, rd1_gnt}, 0);

    // resync mid-fill
    pix(1);
    while (m_next < 300) pix(0);
    step(0, 1, 1, 8'hAA, 0, 0, 0, '0, '0);
    chk("resync_wren", ram_wren_a, 1);
    chk("resync_addr", ram_address_a, 0);
    idle();
    chk("resync_flag", resync, 1);
    repeat (FP - 2) pix(0);
    idle();
    chk("resync_not_yet", frame_ready, 0);
    pix(0);
    idle();
    chk("resync_ready", frame_ready, 1);
    step(0, 0, 0, 8'h00, 1, 0, 0, '0, '0);

    // read-behind window at wr_addr=100
    pix(1);
    while (m_next < 100) pix(0);
    repeat (2) begin
      step(0, 0, 0, 8'h00, 0, 1, 1, 99, 100);
      chk("rb_gnt0", rd0_gnt, BEHIND);
      chk("rb_gnt1", rd1_gnt, 0);
    end
    step(0, 1, 0, 8'(m_next), 0, 1, 1, 99, 100);
    chk("rb_wr_gnt0", rd0_gnt, BEHIND);
    chk("rb_wr_gnt1", rd1_gnt, 0);
    step(0, 0, 0, 8'h00, 0, 1, 1, 99, 100);
    chk("rb_after_gnt1", rd1_gnt, BEHIND);
    chk("rb_after_gnt0", rd0_gnt, 0);
    idle();

    // reset mid-fill at wr_addr=500
    while (m_next < 500) pix(0);
    step(1, 1, 0, 8'h11, 0, 0, 0, '0, '0);
    step(0, 1, 0, 8'h12, 0, 0, 0, '0, '0);
    chk("mrst_wren", ram_wren_a, 0);
    chk("mrst_ready", frame_ready, 0);
    idle();
    pix(1);
    repeat (FP - 1) pix(0);
    step(0, 0, 0, 8'h00, 0, 1, 1, 7, 8);
    chk("mrst_rr_gnt0", rd0_gnt, 1);
    step(0, 0, 0, 8'h00, 1, 0, 0, '0, '0);

    // random soak
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 999) == 0);
      v  = ($urandom_range(0, 3) != 0);
      s  = (m_phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1999) == 0);
      rl = ($urandom_range(0, 39) == 0);
      q0 = $urandom_range(0, 1);
      q1 = $urandom_range(0, 1);
      a0i = $urandom_range(0, 1) ? m_next + $urandom_range(0, 4) - 2 : $urandom_range(0, FP - 1);
      a1i = $urandom_range(0, 1) ? m_next + $urandom_range(0, 4) - 2 : $urandom_range(0, FP - 1);
      if (a0i < 0) a0i = 0;
      if (a0i > FP - 1) a0i = FP - 1;
      if (a1i < 0) a1i = 0;
      if (a1i > FP - 1) a1i = FP - 1;
      ad0 = AW'(a0i);
      ad1 = AW'(a1i);
      step(r, v, s, 8'($urandom), rl, q0, q1, ad0, ad1);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
